id_ex_issue: RTL and testbench
==============================

Name: id_ex_issue

Overview:
- ID/EX pipeline register and EX-stage operand issue for the L1-cache pipelined CPU.
- Captures decoded ID-stage fields and generates the 3-bit ALU control code (ADD 010, SUB 110, AND 000, OR 001, MUL 111).
- Selects forwarded operands from EX/MEM and MEM/WB.
- Drives the data1/data2/ALUCtrl inputs of the EX-stage ALU, and carries the MEM/WB control bits onward.

Parameters:
- DW, 32, datapath width
- AW, 5, register-address width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- stall_i  in  1  hold all registers (cache miss / hazard)
- flush_i  in  1  load a bubble instead of ID fields
- id_valid_i  in  1  ID stage holds a real instruction
- rs_data_i  in  DW  register-file read port 1
- rt_data_i  in  DW  register-file read port 2
- imm_i  in  DW  sign-extended immediate
- rs_addr_i  in  AW  source register 1 address
- rt_addr_i  in  AW  source register 2 address
- rd_addr_i  in  AW  destination register address
- alu_op_i  in  2  main-control ALUOp
- funct_i  in  6  R-type funct field
- alu_src_i  in  1  1 = immediate as operand 2
- reg_dst_i  in  1  1 = rd, 0 = rt as write destination
- reg_write_i  in  1  RegWrite control
- mem_read_i  in  1  MemRead control
- mem_write_i  in  1  MemWrite control
- mem_to_reg_i  in  1  MemtoReg control
- exmem_reg_write_i  in  1  EX/MEM RegWrite
- exmem_rd_i  in  AW  EX/MEM destination
- exmem_data_i  in  DW  EX/MEM ALU result
- memwb_reg_write_i  in  1  MEM/WB RegWrite
- memwb_rd_i  in  AW  MEM/WB destination
- memwb_data_i  in  DW  MEM/WB writeback data
- data1_o  out  DW  ALU operand 1
- data2_o  out  DW  ALU operand 2
- alu_ctrl_o  out  3  ALU control code
- store_data_o  out  DW  forwarded rt value for sw
- wr_addr_o  out  AW  selected destination (rd or rt)
- valid_o  out  1  EX stage holds a real instruction
- reg_write_o  out  1  registered RegWrite, gated by valid
- mem_read_o  out  1  registered MemRead, gated by valid
- mem_write_o  out  1  registered MemWrite, gated by valid
- mem_to_reg_o  out  1  registered MemtoReg
- illegal_o  out  1  unknown funct with ALUOp 10, gated by valid

Behaviour:
- Register update on the rising clk_i edge, priority rst_i > stall_i > flush_i > load.
- rst_i: every register is cleared to 0. Resulting outputs: valid_o, all controls, illegal_o and addresses 0; alu_ctrl_o 000; data outputs 0.
- stall_i: all registers hold. A flush_i in the same cycle is ignored; upstream re-asserts it while ID is also stalled.
- flush_i: valid, control bits and illegal are cleared; data/address registers may load or hold (don't-care), because outputs are gated.
- Load: all ID fields are captured; valid is set from id_valid_i.
- Latency: 1 cycle, ID inputs to EX outputs. Forwarding and operand muxing are combinational from the registered values and the live EX/MEM and MEM/WB inputs.
- ALU control decode is done in ID and registered:
  - ALUOp 00 → 010
  - ALUOp 01 → 110
  - ALUOp 11 → 001
  - ALUOp 10 by funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 011000 → 111
  - ALUOp 10, other funct → 011 (ALU outputs 0) and illegal is set
- wr_addr_o = reg_dst ? rd : rt.
- Forwarding for rs (rt identical):
  - EX/MEM match (reg_write=1, rd≠0, rd==rs) → exmem_data_i.
  - Otherwise MEM/WB match, same rules → memwb_data_i.
  - Otherwise the registered rs data.
  - EX/MEM wins when both stages match. Register 0 is never forwarded.
- data1_o = fwd_rs. data2_o = alu_src ? imm : fwd_rt. store_data_o = fwd_rt.
- Outputs while valid_o=0: reg_write_o, mem_read_o, mem_write_o and illegal_o are 0. Data outputs are don't-care.

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: forwarding network as above.
- Undefined: fwd_rs/fwd_rt are the registered read data; the exmem_*/memwb_* inputs are unused. The hazard unit must stall until writeback.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU control codes (ALU_ADD 010, ALU_SUB 110, ALU_AND 000, ALU_OR 001, ALU_MUL 111, ALU_NOP 011)
  - funct constants
  - ALUOp encodings
  - Width constants
- One sub-module, fwd_mux: a combinational 3-way forward select, instantiated once for rs and once for rt.

Test Plan:
- Reset mid-operation: load an add, then assert rst_i for 1 cycle → next cycle valid_o=0, reg_write_o=0, alu_ctrl_o=000, data1_o=0.
- Decode: ALUOp=10 with funct 100010 → alu_ctrl_o=110 after 1 cycle. Funct 011000 → 111. Funct 111111 → 011 with illegal_o=1. ALUOp=00 → 010.
- Forward priority: rs_addr=3, rs_data=0x11; exmem rd=3, data 0x22, reg_write=1; memwb rd=3, data 0x33 → data1_o=0x22. Drop exmem_reg_write → 0x33. With rs_addr=0 and both rd=0 → 0x11.
- alu_src: imm=0xFFFFFFFC, alu_src=1, rt forwarded as 0x55 → data2_o=0xFFFFFFFC, store_data_o=0x55.
- Stall vs flush: load a sw, then stall_i=1 and flush_i=1 for 3 cycles → outputs unchanged, mem_write_o=1. Then flush_i alone → mem_write_o=0, valid_o=0.
- Forwarding disabled (build without ID_EX_FORWARD_EN): repeat the forward-priority scenario → data1_o=0x11 for all cases.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the L1-cache pipelined CPU: ALU control codes, funct/ALUOp
// encodings, datapath widths, and the ID-stage ALU control decoder.
package cpu_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned AddrW = 5;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOP = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  typedef struct packed {
    logic       illegal;
    logic [2:0] ctrl;
  } alu_dec_t;

  // Control bits carried from ID into EX; cleared as a whole for a bubble.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       illegal;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_ctrl;
  } ex_ctrl_t;

  function automatic alu_dec_t alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
    alu_dec_t dec;
    dec.illegal = 1'b0;
    dec.ctrl    = ALU_ADD;
    unique case (alu_op)
      ALUOP_ADD: dec.ctrl = ALU_ADD;
      ALUOP_SUB: dec.ctrl = ALU_SUB;
      ALUOP_OR:  dec.ctrl = ALU_OR;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: dec.ctrl = ALU_ADD;
          FUNCT_SUB: dec.ctrl = ALU_SUB;
          FUNCT_AND: dec.ctrl = ALU_AND;
          FUNCT_OR:  dec.ctrl = ALU_OR;
          FUNCT_MUL: dec.ctrl = ALU_MUL;
          default: begin
            dec.ctrl    = ALU_NOP;
            dec.illegal = 1'b1;
          end
        endcase
      end
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Combinational 3-way operand forward select: EX/MEM over MEM/WB over register-file data.
// Register 0 is never forwarded.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int unsigned DW = DataW,
  parameter int unsigned AW = AddrW
) (
  input  logic [AW-1:0] src_addr_i,
  input  logic [DW-1:0] src_data_i,
  input  logic          exmem_reg_write_i,
  input  logic [AW-1:0] exmem_rd_i,
  input  logic [DW-1:0] exmem_data_i,
  input  logic          memwb_reg_write_i,
  input  logic [AW-1:0] memwb_rd_i,
  input  logic [DW-1:0] memwb_data_i,
  output logic [DW-1:0] data_o
);

  logic ex_hit;
  logic wb_hit;

  assign ex_hit = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == src_addr_i);
  assign wb_hit = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == src_addr_i);

  always_comb begin
    data_o = src_data_i;
    if (ex_hit) begin
      data_o = exmem_data_i;
    end else if (wb_hit) begin
      data_o = memwb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_issue.sv
// ID/EX pipeline register with ALU control decode and EX operand issue.
// Define ID_EX_FORWARD_EN to enable the EX/MEM and MEM/WB forwarding network.
module id_ex_issue
  import cpu_pkg::*;
#(
  parameter int unsigned DW = DataW,
  parameter int unsigned AW = AddrW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          id_valid_i,
  input  logic [DW-1:0] rs_data_i,
  input  logic [DW-1:0] rt_data_i,
  input  logic [DW-1:0] imm_i,
  input  logic [AW-1:0] rs_addr_i,
  input  logic [AW-1:0] rt_addr_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic [1:0]    alu_op_i,
  input  logic [5:0]    funct_i,
  input  logic          alu_src_i,
  input  logic          reg_dst_i,
  input  logic          reg_write_i,
  input  logic          mem_read_i,
  input  logic          mem_write_i,
  input  logic          mem_to_reg_i,
  input  logic          exmem_reg_write_i,
  input  logic [AW-1:0] exmem_rd_i,
  input  logic [DW-1:0] exmem_data_i,
  input  logic          memwb_reg_write_i,
  input  logic [AW-1:0] memwb_rd_i,
  input  logic [DW-1:0] memwb_data_i,
  output logic [DW-1:0] data1_o,
  output logic [DW-1:0] data2_o,
  output logic [2:0]    alu_ctrl_o,
  output logic [DW-1:0] store_data_o,
  output logic [AW-1:0] wr_addr_o,
  output logic          valid_o,
  output logic          reg_write_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
  output logic          mem_to_reg_o,
  output logic          illegal_o
);

  ex_ctrl_t      ctrl_d, ctrl_q;
  logic [DW-1:0] rs_data_d, rs_data_q;
  logic [DW-1:0] rt_data_d, rt_data_q;
  logic [DW-1:0] imm_d, imm_q;
  logic [AW-1:0] rs_addr_d, rs_addr_q;
  logic [AW-1:0] rt_addr_d, rt_addr_q;
  logic [AW-1:0] rd_addr_d, rd_addr_q;
  alu_dec_t      dec;

  always_comb begin
    dec       = alu_decode(alu_op_i, funct_i);
    ctrl_d    = ctrl_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rd_addr_d = rd_addr_q;
    if (!stall_i) begin
      // Data fields load even on flush; the cleared valid/control bits mask them.
      rs_data_d = rs_data_i;
      rt_data_d = rt_data_i;
      imm_d     = imm_i;
      rs_addr_d = rs_addr_i;
      rt_addr_d = rt_addr_i;
      rd_addr_d = rd_addr_i;
      if (flush_i) begin
        ctrl_d = '0;
      end else begin
        ctrl_d = '{valid:      id_valid_i,
                   reg_write:  reg_write_i,
                   mem_read:   mem_read_i,
                   mem_write:  mem_write_i,
                   mem_to_reg: mem_to_reg_i,
                   illegal:    dec.illegal,
                   alu_src:    alu_src_i,
                   reg_dst:    reg_dst_i,
                   alu_ctrl:   dec.ctrl};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q    <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  logic          ex_rw;
  logic [AW-1:0] ex_rd;
  logic [DW-1:0] ex_data;
  logic          wb_rw;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;

`ifdef ID_EX_FORWARD_EN
  assign ex_rw   = exmem_reg_write_i;
  assign ex_rd   = exmem_rd_i;
  assign ex_data = exmem_data_i;
  assign wb_rw   = memwb_reg_write_i;
  assign wb_rd   = memwb_rd_i;
  assign wb_data = memwb_data_i;
`else
  // No forwarding: the hazard unit stalls until writeback, so the muxes pass register data.
  assign ex_rw   = 1'b0;
  assign ex_rd   = '0;
  assign ex_data = '0;
  assign wb_rw   = 1'b0;
  assign wb_rd   = '0;
  assign wb_data = '0;
  logic unused_fwd;
  assign unused_fwd = ^{exmem_reg_write_i, exmem_rd_i, exmem_data_i,
                        memwb_reg_write_i, memwb_rd_i, memwb_data_i};
`endif

  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rs (
    .src_addr_i        (rs_addr_q),
    .src_data_i        (rs_data_q),
    .exmem_reg_write_i (ex_rw),
    .exmem_rd_i        (ex_rd),
    .exmem_data_i      (ex_data),
    .memwb_reg_write_i (wb_rw),
    .memwb_rd_i        (wb_rd),
    .memwb_data_i      (wb_data),
    .data_o            (fwd_rs)
  );

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rt (
    .src_addr_i        (rt_addr_q),
    .src_data_i        (rt_data_q),
    .exmem_reg_write_i (ex_rw),
    .exmem_rd_i        (ex_rd),
    .exmem_data_i      (ex_data),
    .memwb_reg_write_i (wb_rw),
    .memwb_rd_i        (wb_rd),
    .memwb_data_i      (wb_data),
    .data_o            (fwd_rt)
  );

  assign data1_o      = fwd_rs;
  assign data2_o      = ctrl_q.alu_src ? imm_q : fwd_rt;
  assign store_data_o = fwd_rt;
  assign wr_addr_o    = ctrl_q.reg_dst ? rd_addr_q : rt_addr_q;
  assign alu_ctrl_o   = ctrl_q.alu_ctrl;
  assign valid_o      = ctrl_q.valid;
  assign reg_write_o  = ctrl_q.valid & ctrl_q.reg_write;
  assign mem_read_o   = ctrl_q.valid & ctrl_q.mem_read;
  assign mem_write_o  = ctrl_q.valid & ctrl_q.mem_write;
  assign mem_to_reg_o = ctrl_q.mem_to_reg;
  assign illegal_o    = ctrl_q.valid & ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_issue.sv
// Table-driven bench for id_ex_issue with a scoreboard queue plus hand-written
// reset and stall/flush sequences. Expectations follow ID_EX_FORWARD_EN.
module tb_id_ex_issue;

`ifdef ID_EX_FORWARD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [31:0] rs_data, rt_data, imm;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic        alu_src, reg_dst, rw, mr, mw, m2r;
  logic        ex_rw, wb_rw;
  logic [4:0]  ex_rd, wb_rd;
  logic [31:0] ex_data, wb_data;
  logic [31:0] d1, d2, st;
  logic [2:0]  ctrl;
  logic [4:0]  wr;
  logic        o_valid, o_rw, o_mr, o_mw, o_m2r, o_ill;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_issue dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .stall_i           (stall),
    .flush_i           (flush),
    .id_valid_i        (id_valid),
    .rs_data_i         (rs_data),
    .rt_data_i         (rt_data),
    .imm_i             (imm),
    .rs_addr_i         (rs_addr),
    .rt_addr_i         (rt_addr),
    .rd_addr_i         (rd_addr),
    .alu_op_i          (alu_op),
    .funct_i           (funct),
    .alu_src_i         (alu_src),
    .reg_dst_i         (reg_dst),
    .reg_write_i       (rw),
    .mem_read_i        (mr),
    .mem_write_i       (mw),
    .mem_to_reg_i      (m2r),
    .exmem_reg_write_i (ex_rw),
    .exmem_rd_i        (ex_rd),
    .exmem_data_i      (ex_data),
    .memwb_reg_write_i (wb_rw),
    .memwb_rd_i        (wb_rd),
    .memwb_data_i      (wb_data),
    .data1_o           (d1),
    .data2_o           (d2),
    .alu_ctrl_o        (ctrl),
    .store_data_o      (st),
    .wr_addr_o         (wr),
    .valid_o           (o_valid),
    .reg_write_o       (o_rw),
    .mem_read_o        (o_mr),
    .mem_write_o       (o_mw),
    .mem_to_reg_o      (o_m2r),
    .illegal_o         (o_ill)
  );

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        alu_src, reg_dst, rw, mr, mw, m2r;
    logic        ex_rw, wb_rw;
    logic [4:0]  ex_rd, wb_rd;
    logic [31:0] ex_data, wb_data;
    logic        chk_data;
    logic        e_valid, e_rw, e_mr, e_mw, e_m2r, e_ill;
    logic [2:0]  e_ctrl;
    logic [4:0]  e_wr;
    logic [31:0] e_d1, e_d2, e_st;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.valid;   rs_data = v.rs_data; rt_data = v.rt_data; imm = v.imm;
    rs_addr  = v.rs_addr; rt_addr = v.rt_addr; rd_addr = v.rd_addr;
    alu_op   = v.alu_op;  funct   = v.funct;   alu_src = v.alu_src; reg_dst = v.reg_dst;
    rw = v.rw; mr = v.mr; mw = v.mw; m2r = v.m2r;
    ex_rw = v.ex_rw; ex_rd = v.ex_rd; ex_data = v.ex_data;
    wb_rw = v.wb_rw; wb_rd = v.wb_rd; wb_data = v.wb_data;
  endtask

  task automatic compare(input vec_t e);
    chk({e.name, ".valid"},     {31'd0, o_valid}, {31'd0, e.e_valid});
    chk({e.name, ".reg_write"}, {31'd0, o_rw},    {31'd0, e.e_rw});
    chk({e.name, ".mem_read"},  {31'd0, o_mr},    {31'd0, e.e_mr});
    chk({e.name, ".mem_write"}, {31'd0, o_mw},    {31'd0, e.e_mw});
    chk({e.name, ".illegal"},   {31'd0, o_ill},   {31'd0, e.e_ill});
    if (e.chk_data) begin
      chk({e.name, ".mem_to_reg"}, {31'd0, o_m2r}, {31'd0, e.e_m2r});
      chk({e.name, ".alu_ctrl"},   {29'd0, ctrl},  {29'd0, e.e_ctrl});
      chk({e.name, ".wr_addr"},    {27'd0, wr},    {27'd0, e.e_wr});
      chk({e.name, ".data1"},      d1,             e.e_d1);
      chk({e.name, ".data2"},      d2,             e.e_d2);
      chk({e.name, ".store"},      st,             e.e_st);
    end
  endtask

  vec_t base, v, add_v, sw_v;

  initial begin
    base = '{name: "base", valid: 1'b1, rs_data: 0, rt_data: 0, imm: 0, rs_addr: 0, rt_addr: 0,
             rd_addr: 0, alu_op: 2'b00, funct: 6'b0, alu_src: 0, reg_dst: 0, rw: 0, mr: 0, mw: 0,
             m2r: 0, ex_rw: 0, wb_rw: 0, ex_rd: 0, wb_rd: 0, ex_data: 0, wb_data: 0,
             chk_data: 1'b1, e_valid: 1'b1, e_rw: 0, e_mr: 0, e_mw: 0, e_m2r: 0, e_ill: 0,
             e_ctrl: 3'b010, e_wr: 0, e_d1: 0, e_d2: 0, e_st: 0};

    // add $4, $1, $2
    v = base; v.name = "add"; v.rs_addr = 1; v.rs_data = 32'h100; v.rt_addr = 2;
    v.rt_data = 32'h200; v.rd_addr = 4; v.reg_dst = 1; v.rw = 1; v.e_rw = 1; v.e_wr = 4;
    v.e_d1 = 32'h100; v.e_d2 = 32'h200; v.e_st = 32'h200;
    add_v = v; tbl.push_back(v);
    v = add_v; v.name = "sub"; v.alu_op = 2'b10; v.funct = 6'b100010; v.e_ctrl = 3'b110;
    tbl.push_back(v);
    v = add_v; v.name = "mul"; v.alu_op = 2'b10; v.funct = 6'b011000; v.e_ctrl = 3'b111;
    v.reg_dst = 0; v.e_wr = 2; tbl.push_back(v);
    v = add_v; v.name = "bad_funct"; v.alu_op = 2'b10; v.funct = 6'b111111; v.e_ctrl = 3'b011;
    v.e_ill = 1; tbl.push_back(v);
    v = add_v; v.name = "and"; v.alu_op = 2'b10; v.funct = 6'b100100; v.e_ctrl = 3'b000;
    tbl.push_back(v);
    v = add_v; v.name = "or"; v.alu_op = 2'b10; v.funct = 6'b100101; v.e_ctrl = 3'b001;
    tbl.push_back(v);
    v = add_v; v.name = "rfunct_add"; v.alu_op = 2'b10; v.funct = 6'b100000; v.e_ctrl = 3'b010;
    tbl.push_back(v);
    v = add_v; v.name = "beq"; v.alu_op = 2'b01; v.rw = 0; v.e_rw = 0; v.e_ctrl = 3'b110;
    tbl.push_back(v);
    v = add_v; v.name = "ori"; v.alu_op = 2'b11; v.e_ctrl = 3'b001; tbl.push_back(v);
    // Forward priority on rs
    v = base; v.name = "fwd_both"; v.rs_addr = 3; v.rs_data = 32'h11; v.ex_rw = 1; v.ex_rd = 3;
    v.ex_data = 32'h22; v.wb_rw = 1; v.wb_rd = 3; v.wb_data = 32'h33;
    v.e_d1 = FwdEn ? 32'h22 : 32'h11; tbl.push_back(v);
    v.name = "fwd_wb"; v.ex_rw = 0; v.e_d1 = FwdEn ? 32'h33 : 32'h11; tbl.push_back(v);
    v.name = "fwd_r0"; v.rs_addr = 0; v.ex_rw = 1; v.ex_rd = 0; v.wb_rd = 0; v.e_d1 = 32'h11;
    tbl.push_back(v);
    // Immediate operand with forwarded rt for sw
    v = base; v.name = "alu_src"; v.imm = 32'hFFFF_FFFC; v.alu_src = 1; v.rt_addr = 5;
    v.rt_data = 32'h9; v.ex_rw = 1; v.ex_rd = 5; v.ex_data = 32'h55; v.e_wr = 5;
    v.e_d2 = 32'hFFFF_FFFC; v.e_st = FwdEn ? 32'h55 : 32'h9; tbl.push_back(v);
    // rt forwarded from MEM/WB only
    v = base; v.name = "fwd_rt_wb"; v.rt_addr = 7; v.rt_data = 32'hA; v.wb_rw = 1; v.wb_rd = 7;
    v.wb_data = 32'hBEEF; v.e_wr = 7; v.e_d2 = FwdEn ? 32'hBEEF : 32'hA;
    v.e_st = FwdEn ? 32'hBEEF : 32'hA; tbl.push_back(v);
    v = base; v.name = "lw"; v.mr = 1; v.m2r = 1; v.rw = 1; v.alu_src = 1; v.imm = 32'h10;
    v.e_mr = 1; v.e_m2r = 1; v.e_rw = 1; v.e_d2 = 32'h10; tbl.push_back(v);
    // Bubble from ID: controls and illegal must be gated off
    v = base; v.name = "id_invalid"; v.valid = 0; v.rw = 1; v.mr = 1; v.mw = 1;
    v.alu_op = 2'b10; v.funct = 6'b111111; v.chk_data = 0; v.e_valid = 0; tbl.push_back(v);

    rst = 1; stall = 0; flush = 0;
    drive(base);
    id_valid = 0;
    tick(); tick();
    chk("rst.valid",     {31'd0, o_valid}, 32'd0);
    chk("rst.reg_write", {31'd0, o_rw},    32'd0);
    chk("rst.mem_write", {31'd0, o_mw},    32'd0);
    chk("rst.illegal",   {31'd0, o_ill},   32'd0);
    chk("rst.alu_ctrl",  {29'd0, ctrl},    32'd0);
    chk("rst.wr_addr",   {27'd0, wr},      32'd0);
    chk("rst.data1",     d1,               32'd0);
    chk("rst.data2",     d2,               32'd0);
    rst = 0;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      tick();
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: queue empty at vector %0d", i);
      end else begin
        compare(exp_q.pop_front());
      end
    end

    // Reset mid-operation
    drive(add_v);
    tick();
    chk("midrst.pre_valid", {31'd0, o_valid}, 32'd1);
    rst = 1;
    tick();
    rst = 0;
    chk("midrst.valid",     {31'd0, o_valid}, 32'd0);
    chk("midrst.reg_write", {31'd0, o_rw},    32'd0);
    chk("midrst.alu_ctrl",  {29'd0, ctrl},    32'd0);
    chk("midrst.data1",     d1,               32'd0);

    // Stall dominates flush; flush alone then bubbles
    sw_v = base; sw_v.mw = 1; sw_v.alu_src = 1; sw_v.imm = 32'h8; sw_v.rs_addr = 1;
    sw_v.rs_data = 32'h40; sw_v.rt_addr = 2; sw_v.rt_data = 32'h77;
    drive(sw_v);
    tick();
    chk("sw.mem_write", {31'd0, o_mw}, 32'd1);
    stall = 1; flush = 1;
    mw = 0; rs_data = 32'hDEAD; rt_data = 32'hBEEF; imm = 32'h1234; alu_op = 2'b01;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall.mem_write", {31'd0, o_mw},    32'd1);
      chk("stall.valid",     {31'd0, o_valid}, 32'd1);
      chk("stall.data1",     d1,               32'h40);
      chk("stall.data2",     d2,               32'h8);
      chk("stall.store",     st,               32'h77);
      chk("stall.alu_ctrl",  {29'd0, ctrl},    32'b010);
    end
    stall = 0; flush = 1;
    drive(sw_v);
    tick();
    flush = 0;
    chk("flush.mem_write", {31'd0, o_mw},    32'd0);
    chk("flush.valid",     {31'd0, o_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
